// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: control inputs from the core and the PC/squash outputs.
// The sequencer connects through the master modport, its environment through the slave modport.
interface pc_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                 stall;
  logic                 halt;
  logic                 PCsrc;
  logic [31:0]          targetPC;
  logic [31:0]          PC;
  logic                 nop;
  logic                 halted;
  logic [CNT_WIDTH-1:0] takenCount;

  modport master (
    input  stall, halt, PCsrc, targetPC,
    output PC, nop, halted, takenCount
  );

  modport slave (
    output stall, halt, PCsrc, targetPC,
    input  PC, nop, halted, takenCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, taken redirects with a registered nop bubble window,
// stall/halt handling and a saturating redirect counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic             clock,
  input logic             reset,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_t;

  localparam logic [2:0]           FlushInit = 3'(FLUSH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          pc_inc;

  // Target low bits are architecturally discarded.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^bus.targetPC[1:0];

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else if (!bus.stall) begin
          if (bus.PCsrc) begin
            pc_d = {bus.targetPC[31:2], 2'b00};
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CntOne;
            end
            if (FLUSH_CYCLES != 0) begin
              state_d = StFlush;
              fcnt_d  = FlushInit;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StFlush: begin
        // Wrong-path redirects are not possible here: the branch unit is squashed too.
        if (bus.halt) begin
          state_d = StHalt;
        end else if (!bus.stall) begin
          pc_d   = pc_inc;
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) begin
            state_d = StRun;
          end
        end
      end
      StHalt: begin
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      fcnt_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.nop        = (state_q != StRun);
  assign bus.halted     = (state_q == StHalt);
  assign bus.takenCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: three sequencer configurations share one randomized stimulus stream and are
// compared every cycle against a behavioural model, plus directed literal expectations.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, halt, PCsrc;
  logic [31:0] targetPC;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  pc_sequencer_if #(.CNT_WIDTH(16)) bus_a ();
  pc_sequencer_if #(.CNT_WIDTH(16)) bus_b ();
  pc_sequencer_if #(.CNT_WIDTH(2))  bus_c ();

  assign bus_a.stall = stall;  assign bus_a.halt = halt;
  assign bus_a.PCsrc = PCsrc;  assign bus_a.targetPC = targetPC;
  assign bus_b.stall = stall;  assign bus_b.halt = halt;
  assign bus_b.PCsrc = PCsrc;  assign bus_b.targetPC = targetPC;
  assign bus_c.stall = stall;  assign bus_c.halt = halt;
  assign bus_c.PCsrc = PCsrc;  assign bus_c.targetPC = targetPC;

  pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );
  pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(0), .CNT_WIDTH(16)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );
  pc_sequencer #(.RESET_PC(32'h40), .FLUSH_CYCLES(0), .CNT_WIDTH(2)) dut_c (
    .clock (clock), .reset (reset), .bus (bus_c)
  );

  // Model: remaining bubble cycles as a plain integer, halt as a flag.
  typedef struct {
    logic [31:0] pc;
    int          bub;
    bit          hlt;
    int unsigned cnt;
  } mdl_t;

  mdl_t ma, mb, mc;
  bit   mvalid = 1'b0;

  function automatic mdl_t step_mdl(mdl_t m, int flush, int unsigned cmax, logic [31:0] rpc);
    mdl_t n = m;
    if (!reset) begin
      n.pc = rpc; n.bub = 0; n.hlt = 1'b0; n.cnt = 0;
    end else if (m.hlt) begin
      n = m;
    end else if (halt) begin
      n.hlt = 1'b1;
    end else if (stall) begin
      n = m;
    end else if (m.bub > 0) begin
      n.pc  = m.pc + 32'd4;
      n.bub = m.bub - 1;
    end else if (PCsrc) begin
      n.pc  = targetPC & 32'hFFFF_FFFC;
      n.bub = flush;
      if (m.cnt < cmax) n.cnt = m.cnt + 1;
    end else begin
      n.pc = m.pc + 32'd4;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    ma <= step_mdl(ma, 2, 65535, 32'h100);
    mb <= step_mdl(mb, 0, 65535, 32'h100);
    mc <= step_mdl(mc, 0, 3, 32'h40);
    if (!reset) mvalid <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] pc, input logic nop_v,
                     input logic hlt_v, input logic [31:0] cnt, input mdl_t m);
    chk({tag, ".PC"}, pc, m.pc);
    chk({tag, ".nop"}, 32'(nop_v), 32'(m.hlt || (m.bub > 0)));
    chk({tag, ".halted"}, 32'(hlt_v), 32'(m.hlt));
    chk({tag, ".takenCount"}, cnt, m.cnt);
  endtask

  always @(negedge clock) begin
    if (mvalid) begin
      cmp("a", bus_a.PC, bus_a.nop, bus_a.halted, 32'(bus_a.takenCount), ma);
      cmp("b", bus_b.PC, bus_b.nop, bus_b.halted, 32'(bus_b.takenCount), mb);
      cmp("c", bus_c.PC, bus_c.nop, bus_c.halted, 32'(bus_c.takenCount), mc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lit_a(input string name, input logic [31:0] pc, input logic nop_v,
                       input logic hlt_v, input logic [31:0] cnt);
    chk({"lit_", name, ".PC"}, bus_a.PC, pc);
    chk({"lit_", name, ".nop"}, 32'(bus_a.nop), 32'(nop_v));
    chk({"lit_", name, ".halted"}, 32'(bus_a.halted), 32'(hlt_v));
    chk({"lit_", name, ".takenCount"}, 32'(bus_a.takenCount), cnt);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; halt = 1'b0; PCsrc = 1'b0; targetPC = 32'h0;
    step(); step();
    lit_a("reset", 32'h100, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step(); lit_a("seq1", 32'h104, 1'b0, 1'b0, 0);
    step(); lit_a("seq2", 32'h108, 1'b0, 1'b0, 0);
    // Redirect, with PCsrc held through the first flush cycle.
    PCsrc = 1'b1; targetPC = 32'h203;
    step(); lit_a("redir0", 32'h200, 1'b1, 1'b0, 1);
    step(); lit_a("redir1", 32'h204, 1'b1, 1'b0, 1);
    PCsrc = 1'b0;
    step(); lit_a("redir2", 32'h208, 1'b0, 1'b0, 1);
    // Stall in RUN masks PCsrc.
    stall = 1'b1; PCsrc = 1'b1; targetPC = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step(); lit_a("stall_run", 32'h208, 1'b0, 1'b0, 1);
    end
    stall = 1'b0;
    step(); lit_a("redir_b0", 32'h400, 1'b1, 1'b0, 2);
    PCsrc = 1'b0; stall = 1'b1;
    step(); lit_a("stall_flush", 32'h400, 1'b1, 1'b0, 2);
    stall = 1'b0;
    step(); lit_a("flush_adv", 32'h404, 1'b1, 1'b0, 2);
    step(); lit_a("flush_end", 32'h408, 1'b0, 1'b0, 2);
    // Halt wins over PCsrc and holds until reset.
    halt = 1'b1; PCsrc = 1'b1; targetPC = 32'h800;
    step(); lit_a("halt0", 32'h408, 1'b1, 1'b1, 2);
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); lit_a("halt_hold", 32'h408, 1'b1, 1'b1, 2);
    end
    reset = 1'b0; PCsrc = 1'b0;
    step(); lit_a("halt_reset", 32'h100, 1'b0, 1'b0, 0);
    reset = 1'b1;
    // Wrap at the top of the address space.
    PCsrc = 1'b1; targetPC = 32'hFFFF_FFFF;
    step(); lit_a("wrap0", 32'hFFFF_FFFC, 1'b1, 1'b0, 1);
    PCsrc = 1'b0;
    step(); lit_a("wrap1", 32'h0000_0000, 1'b1, 1'b0, 1);
    step(); lit_a("wrap2", 32'h0000_0004, 1'b0, 1'b0, 1);
    // Back-to-back redirects with no flush window; dut_c saturates at 3.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCsrc = 1'b1; targetPC = 32'h1000 + 32'(i) * 32'h10 + 32'h1;
      step();
      chk("f0.PC", bus_b.PC, 32'h1000 + 32'(i) * 32'h10);
      chk("f0.nop", 32'(bus_b.nop), 32'h0);
      chk("f0.takenCount", 32'(bus_b.takenCount), 32'(i + 1));
      chk("sat.takenCount", 32'(bus_c.takenCount), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    PCsrc = 1'b0;
    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 59) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      halt     = ($urandom_range(0, 79) == 0);
      PCsrc    = ($urandom_range(0, 2) == 0);
      targetPC = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
      step();
    end
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
